// File: rtl/run_control_pkg.sv
// Shared types for the EDiC debug run/halt controller: FSM states and halt-cause codes.
package run_control_pkg;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_STEP   = 2'd1;
  localparam logic [1:0] CAUSE_BP     = 2'd2;
  localparam logic [1:0] CAUSE_MANUAL = 2'd3;

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioning: 2-flop synchroniser, stable-level debounce counter and
// a one-cycle pulse when a new pressed level is accepted.
module button_debounce
  import run_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // Counter measures how long the synchronised input has disagreed with the accepted level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/run_control.sv
// Debug run/halt controller: drives the CPU halt from panel buttons/switches, breakpoint
// channels and the instruction-finished pulse; reports halt cause and counts run cycles.
module run_control
  import run_control_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_BP          = 4,
  parameter int STEP_W          = 8
) (
  input  logic                                          i_clk,
  input  logic                                          i_reset,
  input  logic                                          i_btnStep,
  input  logic                                          i_btnRun,
  input  logic                                          i_swInstrNCycle,
  input  logic                                          i_swStepNRun,
  input  logic [STEP_W-1:0]                             i_stepCount,
  input  logic [NUM_BP-1:0]                             i_bpEnable,
  input  logic [NUM_BP-1:0]                             i_bpHit,
  input  logic                                          i_instrFinished,
  output logic                                          o_halt,
  output logic [1:0]                                    o_haltCause,
  output logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] o_bpIndex,
  output logic                                          o_stepBusy,
  output logic [31:0]                                   o_cycleCount
);

  localparam int BPI_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

  logic              stepPulse, runPulse;
  logic              swInstr1_q, swInstr2_q, swStep1_q, swStep2_q;
  state_e            state_q, state_d;
  logic [STEP_W-1:0] remain_q, remain_d;
  logic              unitInstr_q, unitInstr_d;
  logic              mask_q, mask_d;
  logic [1:0]        cause_q, cause_d;
  logic [BPI_W-1:0]  bpIdx_q, bpIdx_d;
  logic [31:0]       cycCnt_q, cycCnt_d;

  logic [NUM_BP-1:0] hitVec;
  logic              hitAny;
  logic [BPI_W-1:0]  hitIdx;
  logic [STEP_W-1:0] stepLoad;
  logic              stepDec;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbStep (
    .clk_i(i_clk), .rst_i(i_reset), .btn_i(i_btnStep), .pulse_o(stepPulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbRun (
    .clk_i(i_clk), .rst_i(i_reset), .btn_i(i_btnRun), .pulse_o(runPulse)
  );

  assign hitVec   = i_bpHit & i_bpEnable;
  // The mask lets the CPU move off a breakpointed address on the first resumed cycle.
  assign hitAny   = (|hitVec) && !mask_q;
  assign stepLoad = (i_stepCount == '0) ? STEP_W'(1) : i_stepCount;
  assign stepDec  = !unitInstr_q || i_instrFinished;

  always_comb begin
    hitIdx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (hitVec[i]) hitIdx = BPI_W'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    unitInstr_d = unitInstr_q;
    mask_d      = 1'b0;
    cause_d     = cause_q;
    bpIdx_d     = bpIdx_q;
    cycCnt_d    = cycCnt_q;
    if (state_q != ST_HALTED) cycCnt_d = cycCnt_q + 32'd1;
    case (state_q)
      ST_HALTED: begin
        if (swStep2_q && stepPulse) begin
          state_d     = ST_STEP;
          remain_d    = stepLoad;
          unitInstr_d = swInstr2_q;
          mask_d      = 1'b1;
        end else if (!swStep2_q && runPulse) begin
          state_d = ST_RUN;
          mask_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (hitAny) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
          bpIdx_d = hitIdx;
        end else if (swStep2_q) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_MANUAL;
        end
      end
      ST_STEP: begin
        if (hitAny) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BP;
          bpIdx_d = hitIdx;
        end else if (stepDec) begin
          if (remain_q == STEP_W'(1)) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_STEP;
          end
          remain_d = remain_q - 1'b1;
        end
      end
      default: state_d = ST_HALTED;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      swInstr1_q  <= 1'b0;
      swInstr2_q  <= 1'b0;
      swStep1_q   <= 1'b0;
      swStep2_q   <= 1'b0;
      state_q     <= ST_HALTED;
      remain_q    <= '0;
      unitInstr_q <= 1'b0;
      mask_q      <= 1'b0;
      cause_q     <= CAUSE_NONE;
      bpIdx_q     <= '0;
      cycCnt_q    <= '0;
    end else begin
      swInstr1_q  <= i_swInstrNCycle;
      swInstr2_q  <= swInstr1_q;
      swStep1_q   <= i_swStepNRun;
      swStep2_q   <= swStep1_q;
      state_q     <= state_d;
      remain_q    <= remain_d;
      unitInstr_q <= unitInstr_d;
      mask_q      <= mask_d;
      cause_q     <= cause_d;
      bpIdx_q     <= bpIdx_d;
      cycCnt_q    <= cycCnt_d;
    end
  end

  assign o_halt       = (state_q == ST_HALTED);
  assign o_stepBusy   = (state_q == ST_STEP);
  assign o_haltCause  = cause_q;
  assign o_bpIndex    = bpIdx_q;
  assign o_cycleCount = cycCnt_q;

endmodule

// File: doc/run_control.md
# run_control

Debug run/halt controller for the EDiC CPU: generates the CPU halt (clock-enable-blocking) signal from front-panel buttons and switches, a parametrised set of breakpoint comparators, and the control unit's instruction-finished pulse. It is the parametrised successor of the fixed single-step clock/halt logic. It adds debounced inputs, multi-unit stepping (N cycles or N instructions per press), NUM_BP breakpoint channels with cause/index reporting, and a run-cycle counter. It sits between the panel I/O and the CPU core, in the core clock domain.

## Interface
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a button level change is accepted (≥1)
- NUM_BP, 4: breakpoint channels (≥1)
- STEP_W, 8: width of step count
- i_clk  in  1  core clock, all logic on rising edge
- i_reset  in  1  one clock; reset is asynchronous and active-high
- i_btnStep  in  1  raw step button, 1 = pressed, asynchronous
- i_btnRun  in  1  raw run/resume button, 1 = pressed, asynchronous
- i_swInstrNCycle  in  1  1 = step unit is instruction, 0 = cycle (2-flop synchronised)
- i_swStepNRun  in  1  1 = step mode, 0 = run mode (2-flop synchronised)
- i_stepCount  in  STEP_W  units per step press; 0 treated as 1; sampled on press
- i_bpEnable  in  NUM_BP  per-channel breakpoint enable
- i_bpHit  in  NUM_BP  per-channel match, active-high, synchronous
- i_instrFinished  in  1  one-cycle pulse on last cycle of each instruction
- o_halt  out  1  1 = CPU stalled; registered
- o_haltCause  out  2  reason for last halt
- o_bpIndex  out  $clog2(NUM_BP) (min 1)  lowest enabled channel that caused last BP halt
- o_stepBusy  out  1  high while in STEP
- o_cycleCount  out  32  cycles with o_halt low

## Operation
- Buttons: 2-flop sync → debounce (counter resets on any level mismatch; new level accepted after DEBOUNCE_CYCLES stable cycles) → one-cycle press pulse on accepted 0→1.
- FSM states HALTED, RUN, STEP. Reset → HALTED, cause NONE (0).
- HALTED: step mode + step pulse → STEP, remaining := max(i_stepCount,1). Run mode + run pulse → RUN. Other pulse ignored.
- RUN: enabled hit (i_bpHit & i_bpEnable ≠ 0) → HALTED, cause BP (2), o_bpIndex := lowest set bit. Sync'd i_swStepNRun = 1 → HALTED, cause MANUAL (3).
- STEP: cycle mode decrements remaining every cycle; instr mode decrements on i_instrFinished. Decrement from 1 → HALTED, cause STEP (1). Enabled hit → HALTED cause BP, priority over step completion in the same cycle.
- Step unit latched at STEP entry; switch changes during STEP take effect next press.
- Breakpoint mask: hits ignored on the first cycle after leaving HALTED, allowing the CPU to leave a breakpointed address.
- Button pulses in RUN/STEP ignored; simultaneous step and run pulses: mode switch selects which acts.
- o_cycleCount: +1 per cycle o_halt=0, wraps at 2^32, cleared only by reset.

## Timing
- Reset values: o_halt=1, o_haltCause=0, o_bpIndex=0, o_stepBusy=0, o_cycleCount=0; asynchronous on i_reset rise.
- Press latency: raw edge → pulse = 2 sync + DEBOUNCE_CYCLES cycles.
- Pulse at cycle t: o_halt low from t+1.
- Cycle step N: o_halt low exactly N cycles (t+1..t+N), high at t+N+1.
- Instr step N: o_halt high the cycle after the Nth i_instrFinished.
- Breakpoint hit at cycle t (unmasked): o_halt high at t+1; CPU executes no further cycle.
- Cause and index update in the same edge o_halt rises; hold until next halt.
- Reset mid-STEP/RUN: immediate HALTED; remaining count discarded.

## Structure
- run_control_pkg: state enum (HALTED/RUN/STEP), cause constants CAUSE_NONE/STEP/BP/MANUAL.
- Sub-module button_debounce (sync, debounce counter, rising-edge pulse; parameter DEBOUNCE_CYCLES), instantiated for step and run.
- Priority encoder for o_bpIndex inline.

## Test plan
- DEBOUNCE_CYCLES=4: step button bounces 1-0-1 every 2 cycles then holds → exactly one pulse, 6 cycles after final stable edge.
- Cycle mode, i_stepCount=3, press → o_halt low exactly 3 cycles, cause 1, o_cycleCount=3; i_stepCount=0 → 1 cycle.
- Instr mode, count 2, i_instrFinished at +4 and +9 → o_halt rises at +10, o_stepBusy low then.
- Run mode, i_bpEnable=4'b1010, i_bpHit=4'b1110 at cycle 20 → halt at 21, cause 2, o_bpIndex=1; run press with hit held → no re-halt on first resumed cycle, halt on second.
- Step completion and enabled hit same cycle → cause 2; switch to step mode during RUN → cause 3.
- i_reset asserted mid-STEP → o_halt=1 immediately, all outputs at reset values; next press starts fresh count.
